// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
//   Streaming 3x3 sliding-window generator. Takes a raster-order pixel stream
//   and emits one packed 3x3 window for every stride-1 position that fits
//   entirely inside the frame (no padding). Two IMG_W-deep line buffers hold
//   the previous two rows. A 3x3 register window shifts left one column per
//   accepted pixel.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_data    input pixel, raster order
//   i_valid   i_data valid
//   o_ready   block can accept i_data this cycle (low while in reset)
//   o_window  packed window, slot k = window row k/3, col k%3 (row 0 = top)
//   o_valid   o_window valid
//   i_ready   downstream accepts o_window
//   o_last    with o_valid: last window of the frame
// -----------------------------------------------------------------------------
module window_gen_3x3 #(
  parameter int DATA_W = 10,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [9*DATA_W-1:0]   o_window,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Raster position of the next pixel to be accepted
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;

  // 3x3 window registers, [row][col], row 0 = oldest line, col 0 = leftmost
  logic [DATA_W-1:0]    win_q [3][3];
  logic [DATA_W-1:0]    win_d [3][3];

  // Line buffers: lb0 = previous row, lb1 = row before that
  logic [DATA_W-1:0]    lb0_q [IMG_W];
  logic [DATA_W-1:0]    lb1_q [IMG_W];

  // Registered output beat
  logic [9*DATA_W-1:0]  out_win_q, out_win_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;

  logic                 accept;
  logic                 consume;
  logic                 win_pos;
  logic                 frame_end;
  logic [DATA_W-1:0]    new_col [3];

  assign o_ready  = i_rst_n && (!out_valid_q || i_ready);
  assign accept   = i_valid && o_ready;
  assign consume  = out_valid_q && i_ready;

  assign o_window = out_win_q;
  assign o_valid  = out_valid_q;
  assign o_last   = out_last_q;

  // A window is complete only once two earlier columns of the same row and
  // two earlier rows of the same frame have been seen, so windows never
  // straddle a row wrap or a frame boundary even though the registers and
  // line buffers are never flushed.
  assign win_pos   = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Incoming column, top to bottom
  assign new_col[0] = lb1_q[col_q];
  assign new_col[1] = lb0_q[col_q];
  assign new_col[2] = i_data;

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_win_d   = out_win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        win_d[r][c] = win_q[r][c];
      end
    end

    if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
        win_d[r][2] = new_col[r];
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (win_pos) begin
        out_valid_d = 1'b1;
        out_last_d  = frame_end;
        for (int unsigned r = 0; r < 3; r++) begin
          for (int unsigned c = 0; c < 3; c++) begin
            out_win_d[DATA_W*(3*r+c) +: DATA_W] = win_d[r][c];
          end
        end
      end else if (consume) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_win_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_win_q   <= out_win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  // Line-buffer contents are don't-care after reset, so they carry no reset.
  // accept is already gated by i_rst_n through o_ready.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= i_data;
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_gen_3x3
//   Self-checking bench for window_gen_3x3 (DATA_W=10, IMG_W=4, IMG_H=4).
//   A frame-image model predicts ready/valid/window/last every cycle; consumed
//   windows are logged and checked against hand-computed literal windows.
// -----------------------------------------------------------------------------
module tb_window_gen_3x3;

  localparam int DW = 10;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WW = 9 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [WW-1:0] o_window;
  logic          o_valid;
  logic          i_ready;
  logic          o_last;

  window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_window(o_window),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Hand-computed windows of a 0..15 frame, in emission order
  int tab [4][9] = '{
    '{0, 1, 2, 4, 5, 6, 8, 9, 10},
    '{1, 2, 3, 5, 6, 7, 9, 10, 11},
    '{4, 5, 6, 8, 9, 10, 12, 13, 14},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15}
  };

  function automatic logic [WW-1:0] pack_tab(input int idx, input int add);
    logic [WW-1:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[DW*k +: DW] = DW'(tab[idx][k] + add);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] img [H][W];
  int            mr, mc;
  logic          exp_valid;
  logic [WW-1:0] exp_win;
  logic          exp_last;
  logic          exp_ready;
  bit            m_acc, m_cons;

  assign exp_ready = rst_n && (!exp_valid || i_ready);

  function automatic logic [WW-1:0] mwin(input int r, input int c);
    logic [WW-1:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[DW*(3*i+j) +: DW] = img[r-2+i][c-2+j];
    return w;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mr = 0; mc = 0;
        exp_valid = 1'b0; exp_win = '0; exp_last = 1'b0;
      end else begin
        m_acc  = i_valid && exp_ready;
        m_cons = exp_valid && i_ready;
        if (m_acc) begin
          img[mr][mc] = i_data;
          if (mr >= 2 && mc >= 2) begin
            exp_valid = 1'b1;
            exp_win   = mwin(mr, mc);
            exp_last  = (mr == H-1) && (mc == W-1);
          end else if (m_cons) begin
            exp_valid = 1'b0;
            exp_last  = 1'b0;
          end
          mc++;
          if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
          end
        end else if (m_cons) begin
          exp_valid = 1'b0;
          exp_last  = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare + window log ----------------
  logic [WW-1:0] log_w [$];
  bit            log_l [$];

  initial begin
    forever begin
      @(negedge clk);
      chk("o_ready", o_ready, exp_ready);
      chk("o_valid", o_valid, exp_valid);
      if (exp_valid || !rst_n) begin
        chk("o_window", o_window, exp_win);
        chk("o_last", o_last, exp_last);
      end
      if (rst_n && o_valid && i_ready) begin
        log_w.push_back(o_window);
        log_l.push_back(o_last);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [DW-1:0] v);
    bit done;
    done    = 1'b0;
    i_valid = 1'b1;
    i_data  = v;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = exp_ready;
      step();
    end
    if (!done) begin
      n_total++;
      $display("FAIL send_timeout: pixel %0d not accepted within 200 cycles", v);
    end
  endtask

  task automatic send_frame(input int base);
    for (int p = 0; p < W*H; p++) send(DW'(base + p));
  endtask

  task automatic check_log(input string nm, input int n, input int b0, input int b1);
    chk($sformatf("%s_count", nm), WW'(log_w.size()), WW'(n));
    for (int i = 0; i < n && i < log_w.size(); i++) begin
      chk($sformatf("%s_win%0d", nm, i), log_w[i], pack_tab(i % 4, (i < 4) ? b0 : b1));
      chk($sformatf("%s_last%0d", nm, i), WW'(log_l[i]), WW'(i % 4 == 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int t;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    repeat (3) step();
    chk("reset_valid", WW'(o_valid), '0);
    chk("reset_ready", WW'(o_ready), '0);
    chk("reset_window", o_window, '0);
    rst_n = 1'b1;
    step();

    // 1: plain frame
    log_w.delete(); log_l.delete();
    send_frame(0);
    idle(4);
    check_log("t1", 4, 0, 0);

    // 2: downstream stall on the first window
    log_w.delete(); log_l.delete();
    fork
      send_frame(0);
      begin
        t = 0;
        while (!exp_valid && t < 100) begin step(); t++; end
        if (!exp_valid) begin
          n_total++;
          $display("FAIL t2_wait: first window never appeared");
        end
        i_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t2_stall_ready", WW'(o_ready), '0);
          chk("t2_stall_valid", WW'(o_valid), WW'(1));
          chk("t2_stall_window", o_window, pack_tab(0, 0));
          step();
        end
        i_ready = 1'b1;
      end
    join
    idle(4);
    check_log("t2", 4, 0, 0);

    // 3: random input gaps
    log_w.delete(); log_l.delete();
    for (int p = 0; p < W*H; p++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      send(DW'(p));
    end
    idle(4);
    check_log("t3", 4, 0, 0);

    // 4: back-to-back frames
    log_w.delete(); log_l.delete();
    send_frame(0);
    send_frame(100);
    idle(4);
    check_log("t4", 8, 0, 100);

    // 5: reset mid-frame
    log_w.delete(); log_l.delete();
    for (int p = 0; p < 8; p++) send(DW'(p));
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("t5_rst_valid", WW'(o_valid), '0);
    chk("t5_rst_window", o_window, '0);
    chk("t5_rst_ready", WW'(o_ready), '0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send_frame(0);
    idle(4);
    check_log("t5", 4, 0, 0);

    // 6: all-ones pixels
    log_w.delete(); log_l.delete();
    for (int p = 0; p < W*H; p++) send('1);
    idle(4);
    chk("t6_count", WW'(log_w.size()), WW'(4));
    for (int i = 0; i < log_w.size(); i++) begin
      chk($sformatf("t6_win%0d", i), log_w[i], {9{10'h3FF}});
      chk($sformatf("t6_last%0d", i), WW'(log_l[i]), WW'(i == 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
